// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mult_state_t;

   localparam int unsigned OP_W_DEFAULT = 6;

   // Iteration counter width; at least one bit so a 1-bit operand still has a counter.
   function automatic int unsigned count_w(input int unsigned op_w);
      return (op_w > 1) ? $clog2(op_w) : 1;
   endfunction

endpackage

// File: rtl/shift_add_multiplier.sv
// Unsigned shift-and-add multiplier: one multiplier bit per clock, product held
// in a register between runs so downstream logic never sees partial sums.
module shift_add_multiplier
   import mult_pkg::*;
#(
   parameter int unsigned OP_W = OP_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [OP_W-1:0]   multiplicand,
   input  logic [OP_W-1:0]   multiplier,
   output logic              busy,
   output logic              done,
   output logic [2*OP_W-1:0] product
);

   localparam int unsigned PROD_W = 2 * OP_W;
   localparam int unsigned CNT_W  = count_w(OP_W);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(OP_W - 1);

   mult_state_t       state,    state_n;
   logic [PROD_W-1:0] mcand_r,  mcand_n;
   logic [OP_W-1:0]   mplier_r, mplier_n;
   logic [PROD_W-1:0] acc,      acc_n;
   logic [CNT_W-1:0]  count,    count_n;
   logic [PROD_W-1:0] prod_r,   prod_n;
   logic [PROD_W-1:0] acc_sum;

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         mcand_r  <= '0;
         mplier_r <= '0;
         acc      <= '0;
         count    <= '0;
         prod_r   <= '0;
      end else begin
         state    <= state_n;
         mcand_r  <= mcand_n;
         mplier_r <= mplier_n;
         acc      <= acc_n;
         count    <= count_n;
         prod_r   <= prod_n;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_n  = state;
      mcand_n  = mcand_r;
      mplier_n = mplier_r;
      acc_n    = acc;
      count_n  = count;
      prod_n   = prod_r;
      acc_sum  = acc + (mplier_r[0] ? mcand_r : '0);

      unique case (state)
         IDLE: begin
            if (start) begin
               mcand_n  = {{OP_W{1'b0}}, multiplicand};
               mplier_n = multiplier;
               acc_n    = '0;
               count_n  = '0;
               state_n  = CALC;
            end
         end
         CALC: begin
            acc_n    = acc_sum;
            mcand_n  = mcand_r << 1;
            mplier_n = mplier_r >> 1;
            count_n  = count + CNT_W'(1);
            // Final iteration publishes the sum including this cycle's add
            if (count == LAST_ITER) begin
               prod_n  = acc_sum;
               state_n = DONE;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign busy    = (state != IDLE);
   assign done    = (state == DONE);
   assign product = prod_r;

endmodule
